mem_arb: RTL and testbench



---
 rtl/mem_arb.sv | 107 ++++++++++
 tb/tb_mem_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one cache-line memory port between L1i refill and L1d refill/writeback
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_addr, i_rd                 instruction line read request (level)
//   i_data, i_dv                 instruction line data, 1-cycle done pulse
//   d_addr, d_rd, d_wr, d_wdata  data line read/write request (level); write wins if both
//   d_rdata, d_dv                data line read data, 1-cycle done pulse (read or write)
//   m_addr, m_rd, m_wr, m_wdata  line-aligned memory request, strobes held until m_ack
//   m_rdata, m_ack               memory read data and 1-cycle completion
//   err                          ack watchdog timeout pulse (TO_CYC = 0 disables it)
module mem_arb #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 1024,
    parameter int TO_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err
);
    localparam int OFFS_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));
    localparam logic [31:0] LIM = 32'(TO_CYC) - 32'd1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t      state, state_nxt;
    logic        last_d;
    logic        op_wr;
    logic [31:0] cnt;
    logic        gnt_i, gnt_d, busy, tmo;

    // On a tie the side that was not served last wins; last_d also names the owner in DONE.
    assign gnt_d = (d_rd || d_wr) && (!i_rd || !last_d);
    assign gnt_i = i_rd && !gnt_d;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);
    // An ack on the limit cycle completes normally instead of timing out.
    assign tmo   = busy && (TO_CYC != 0) && (cnt == LIM) && !m_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            op_wr   <= 1'b0;
            cnt     <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (gnt_i || gnt_d)) begin
                last_d  <= gnt_d;
                op_wr   <= gnt_d && d_wr;
                cnt     <= '0;
                m_addr  <= (gnt_d ? d_addr : i_addr) & LINE_MASK;
                m_wdata <= d_wdata;
            end else if (busy) begin
                cnt <= cnt + 32'd1;
            end
            if (state == BUSY_I && m_ack)
                i_data <= m_rdata;
            if (state == BUSY_D && m_ack && !op_wr)
                d_rdata <= m_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_i)
                    state_nxt = BUSY_I;
                else if (gnt_d)
                    state_nxt = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (m_ack || tmo)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_rd = busy && !op_wr;
        m_wr = busy && op_wr;
        i_dv = (state == DONE) && !last_d;
        d_dv = (state == DONE) && last_d;
        err  = tmo;
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized self-checking bench for mem_arb against a transaction-level model
module tb_mem_arb;
    localparam int AW = 64;
    localparam int LW = 1024;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic          i_rd, d_rd, d_wr, i_dv, d_dv, m_rd, m_wr, m_ack, err;
    logic [LW-1:0] i_data, d_rdata, d_wdata, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_W(AW), .LINE_W(LW), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_dv(d_dv),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    int n_chk = 0;
    int n_err = 0;

    // model state: pending requests, last served side, expected held read data
    bit            ir, dr, dw;
    bit            last_d;
    logic [AW-1:0] ia_q, da_q;
    logic [LW-1:0] wd_q, exp_i, exp_d;

    task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (low 192 bits)", tag, act[191:0], exp[191:0]);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        i_rd = ir; i_addr = ia_q;
        d_rd = dr; d_wr = dw; d_addr = da_q; d_wdata = wd_q;
    endtask

    // k = cycles from first strobe cycle to ack; k > TO means memory never acks
    task automatic txn(input int k);
        bit            win_d, wr;
        int            last_s;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd;
        drive_req();
        win_d  = (dr || dw) && (!ir || !last_d);
        last_d = win_d;
        wr     = win_d && dw;
        ea     = (win_d ? da_q : ia_q) / 128 * 128;
        ewd    = wd_q;
        last_s = (k <= TO) ? k : TO;
        tick();
        for (int s = 1; s <= last_s; s++) begin
            chk("m_rd", m_rd, !wr);
            chk("m_wr", m_wr, wr);
            chk("m_addr", m_addr, ea);
            if (wr) chk("m_wdata", m_wdata, ewd);
            chk("busy_dv", {i_dv, d_dv}, 2'b00);
            i_addr = rand_addr(); d_addr = rand_addr(); d_wdata = rand_line();
            if (s == k) begin
                m_rdata = rand_line();
                m_ack = 1'b1;
                if (!wr) begin
                    if (win_d) exp_d = m_rdata;
                    else exp_i = m_rdata;
                end
            end
            #1;
            chk("err", err, (k > TO) && (s == TO));
            if (s < last_s) tick();
        end
        tick();
        m_ack = 1'b0;
        chk("done_i_dv", i_dv, !win_d);
        chk("done_d_dv", d_dv, win_d);
        chk("done_strobe", {m_rd, m_wr}, 2'b00);
        chk("done_err", err, 1'b0);
        chk("i_data", i_data, exp_i);
        chk("d_rdata", d_rdata, exp_d);
        if (win_d) begin dr = 0; dw = 0; end
        else ir = 0;
        drive_req();
        m_ack = 1'($urandom);
        tick();
        m_ack = 1'b0;
        chk("idle_dv", {i_dv, d_dv}, 2'b00);
        chk("idle_strobe", {m_rd, m_wr}, 2'b00);
    endtask

    task automatic idle_cycle();
        drive_req();
        m_ack = 1'b1;
        m_rdata = rand_line();
        tick();
        m_ack = 1'b0;
        chk("stray_dv", {i_dv, d_dv}, 2'b00);
        chk("stray_strobe", {m_rd, m_wr}, 2'b00);
        chk("stray_i_data", i_data, exp_i);
        chk("stray_d_rdata", d_rdata, exp_d);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_strobe"}, {m_rd, m_wr}, 2'b00);
        chk({tag, "_dv"}, {i_dv, d_dv, err}, 3'b000);
        chk({tag, "_m_addr"}, m_addr, '0);
        chk({tag, "_m_wdata"}, m_wdata, '0);
        chk({tag, "_i_data"}, i_data, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    initial begin
        rst = 1'b1;
        ir = 0; dr = 0; dw = 0; ia_q = '0; da_q = '0; wd_q = '0;
        last_d = 1; exp_i = '0; exp_d = '0;
        m_ack = 1'b0; m_rdata = '0;
        drive_req();
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // lone instruction fetch, ack on the 4th strobe cycle
        ir = 1; ia_q = 64'h1234_5678;
        txn(4);
        // line write with pattern data
        dw = 1; da_q = 64'h80; wd_q = {128{8'hA5}};
        txn(2);
        // read and write together: write issued
        dr = 1; dw = 1; da_q = 64'h1_0000_00C3; wd_q = rand_line();
        txn(1);
        // both sides contending: alternation over several rounds
        for (int r = 0; r < 8; r++) begin
            if (!ir) begin ir = 1; ia_q = rand_addr(); end
            if (!(dr || dw)) begin dr = 1; da_q = rand_addr(); end
            txn($urandom_range(1, 5));
        end
        while (ir || dr || dw) txn(1);
        // watchdog: no ack, then stray acks in idle
        dr = 1; da_q = rand_addr();
        txn(TO + 3);
        idle_cycle();
        idle_cycle();
        // ack exactly on the limit cycle
        ir = 1; ia_q = rand_addr();
        txn(TO);

        // reset mid-transaction
        ir = 1; ia_q = rand_addr();
        drive_req();
        tick();
        chk("pre_rst_m_rd", m_rd, 1'b1);
        tick();
        rst = 1'b1;
        ir = 0; dr = 0; dw = 0;
        drive_req();
        tick();
        check_reset_state("midrst");
        rst = 1'b0;
        last_d = 1; exp_i = '0; exp_d = '0;
        idle_cycle();

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!ir && $urandom_range(0, 1) == 1) begin ir = 1; ia_q = rand_addr(); end
            if (!(dr || dw) && $urandom_range(0, 1) == 1) begin
                int op;
                op = $urandom_range(0, 2);
                dr = (op != 1); dw = (op != 0);
                da_q = rand_addr(); wd_q = rand_line();
            end
            if (!ir && !(dr || dw)) begin
                idle_cycle();
                ir = 1; ia_q = rand_addr();
            end
            txn($urandom_range(1, TO + 2));
        end
        while (ir || dr || dw) txn($urandom_range(1, 4));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
